// File: rtl/minesweeper_pkg.sv
// -----------------------------------------------------------------------------
// minesweeper_pkg
// Shared definitions for the Minesweeper board logic:
//   - cell state encodings stored in the board state array
//   - neighbour-number encoding for a mine
//   - default board geometry
//   - reveal controller FSM state encoding
//   - neighbour direction offset table (dir 0..7 = NW,N,NE,W,E,SW,S,SE)
// -----------------------------------------------------------------------------
package minesweeper_pkg;

   localparam int DEF_ROWS = 5;
   localparam int DEF_COLS = 5;

   localparam logic [1:0] ST_HIDDEN   = 2'd0;
   localparam logic [1:0] ST_REVEALED = 2'd1;
   localparam logic [1:0] ST_FLAGGED  = 2'd2;

   localparam logic [3:0] NUM_ZERO = 4'd0;
   localparam logic [3:0] NUM_MINE = 4'd9;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_POP   = 3'd1,
      S_WAIT  = 3'd2,
      S_EVAL  = 3'd3,
      S_NEIGH = 3'd4,
      S_DONE  = 3'd5
   } fsm_state_t;

   // Row/column offsets, indexed by the 3-bit neighbour direction.
   localparam int DIR_DROW [8] = '{-1, -1, -1,  0, 0,  1, 1, 1};
   localparam int DIR_DCOL [8] = '{-1,  0,  1, -1, 1, -1, 0, 1};

   // Bit width able to hold 0..v-1, never less than 1.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/reveal_fifo.sv
// -----------------------------------------------------------------------------
// reveal_fifo
// Circular FIFO holding cells waiting to be examined by the reveal controller.
// No full check: the caller guarantees at most DEPTH pushes between flushes.
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset (empties the FIFO)
//   flush_i      synchronous flush, takes priority over push/pop
//   push_i       write push_data_i at the tail
//   push_data_i  entry to store
//   pop_i        drop the head entry (ignored while empty)
//   head_o       current head entry, valid while empty_o is low
//   empty_o      FIFO holds no entries
// -----------------------------------------------------------------------------
module reveal_fifo #(
   parameter int DEPTH = 25,
   parameter int WIDTH = 6
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !flush_i;
   assign do_pop  = pop_i && !flush_i && !empty_o;

   // Storage carries no reset; only the pointers define its contents.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/flood_reveal_ctrl.sv
// -----------------------------------------------------------------------------
// flood_reveal_ctrl
// Reveals cells of the Minesweeper board. A flip request reveals one cell; a
// revealed cell whose neighbour number is 0 floods outward through a work
// queue. This block is the only writer of the board state array.
//
// Request handshake: a request is the rising edge of flip. It is accepted only
// when the controller is idle, flip_id addresses a board cell, and the game is
// not over (no mine hit, no win); otherwise it is dropped, never queued. An
// accepted request raises busy on the next cycle, and completes with a
// one-cycle done pulse in the cycle busy falls.
//
// Ports:
//   clock, reset_n          clock (rising edge), async active-low reset
//   flip, flip_id           reveal request level and requested cell index
//   st_rd_addr              read address for the state and number arrays
//   st_rd_data, num_rd_data cell state / number, 1-cycle read latency
//   st_we, st_wr_addr,      state write port; data is always "revealed"
//   st_wr_data
//   busy, done              operation in progress / end-of-operation pulse
//   hit_mine, win           game result flags
//   revealed_cnt            cells revealed since reset
//   dbg_state               current FSM state (fsm_state_t encoding)
// -----------------------------------------------------------------------------
module flood_reveal_ctrl
   import minesweeper_pkg::*;
#(
   parameter int ROWS  = DEF_ROWS,
   parameter int COLS  = DEF_COLS,
   parameter int CELLS = ROWS * COLS,
   parameter int MINES = 4,
   parameter int IDW   = 5
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           flip,
   input  logic [31:0]    flip_id,
   output logic [IDW-1:0] st_rd_addr,
   input  logic [1:0]     st_rd_data,
   input  logic [3:0]     num_rd_data,
   output logic           st_we,
   output logic [IDW-1:0] st_wr_addr,
   output logic [1:0]     st_wr_data,
   output logic           busy,
   output logic           done,
   output logic           hit_mine,
   output logic           win,
   output logic [IDW:0]   revealed_cnt,
   output logic [2:0]     dbg_state
);

   localparam int RW = clog2_min1(ROWS);
   localparam int CW = clog2_min1(COLS);
   localparam int QW = RW + CW;

   fsm_state_t       state_q;
   logic             flip_q;
   logic [CELLS-1:0] mask_q;
   logic [RW-1:0]    cur_row_q;
   logic [CW-1:0]    cur_col_q;
   logic [2:0]       dir_q;

   logic             start;
   logic             accept;
   logic [IDW-1:0]   start_idx;
   logic [RW-1:0]    start_row;
   logic [CW-1:0]    start_col;

   int               nb_r;
   int               nb_c;
   logic             nb_in;
   logic [IDW-1:0]   nb_idx;
   logic             nb_push;

   logic             cell_hidden;
   logic             fifo_push;
   logic [QW-1:0]    fifo_push_data;
   logic             fifo_pop;
   logic             fifo_flush;
   logic [QW-1:0]    fifo_head;
   logic             fifo_empty;
   logic [RW-1:0]    head_row;
   logic [CW-1:0]    head_col;

   function automatic logic [IDW-1:0] cell_idx(input logic [RW-1:0] r,
                                               input logic [CW-1:0] c);
      return IDW'(int'(r) * COLS + int'(c));
   endfunction

   assign dbg_state = state_q;
   assign win = (revealed_cnt == (IDW+1)'(CELLS - MINES)) && !hit_mine;

   // Request qualification
   assign start     = flip && !flip_q;
   assign start_idx = flip_id[IDW-1:0];
   assign start_row = RW'(start_idx / IDW'(COLS));
   assign start_col = CW'(start_idx % IDW'(COLS));
   assign accept    = start && (state_q == S_IDLE) && (flip_id < 32'(CELLS))
                      && !hit_mine && !win;

   // Neighbour of the current cell selected by dir_q. Signed arithmetic so
   // that row/col -1 is recognised as off-board instead of wrapping.
   assign nb_r   = int'(cur_row_q) + DIR_DROW[dir_q];
   assign nb_c   = int'(cur_col_q) + DIR_DCOL[dir_q];
   assign nb_in  = (nb_r >= 0) && (nb_r < ROWS) && (nb_c >= 0) && (nb_c < COLS);
   assign nb_idx = nb_in ? IDW'(nb_r * COLS + nb_c) : '0;
   assign nb_push = (state_q == S_NEIGH) && nb_in && !mask_q[nb_idx];

   assign cell_hidden = (st_rd_data == ST_HIDDEN);

   // Queue control: pushes come from IDLE (start cell) and NEIGH only,
   // pops from POP only, so the two never coincide.
   assign fifo_push      = accept || nb_push;
   assign fifo_push_data = accept ? {start_row, start_col}
                                  : {RW'(nb_r), CW'(nb_c)};
   assign fifo_pop       = (state_q == S_POP);
   assign fifo_flush     = (state_q == S_EVAL) && cell_hidden
                           && (num_rd_data == NUM_MINE);
   assign head_row       = fifo_head[QW-1:CW];
   assign head_col       = fifo_head[CW-1:0];

   reveal_fifo #(
      .DEPTH (CELLS),
      .WIDTH (QW)
   ) u_fifo (
      .clk_i       (clock),
      .rst_ni      (reset_n),
      .flush_i     (fifo_flush),
      .push_i      (fifo_push),
      .push_data_i (fifo_push_data),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .empty_o     (fifo_empty)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         flip_q       <= 1'b0;
         mask_q       <= '0;
         cur_row_q    <= '0;
         cur_col_q    <= '0;
         dir_q        <= '0;
         st_rd_addr   <= '0;
         st_we        <= 1'b0;
         st_wr_addr   <= '0;
         st_wr_data   <= ST_HIDDEN;
         busy         <= 1'b0;
         done         <= 1'b0;
         hit_mine     <= 1'b0;
         revealed_cnt <= '0;
      end else begin
         flip_q     <= flip;
         st_we      <= 1'b0;
         st_wr_data <= ST_HIDDEN;
         done       <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  // Fresh mask per operation, with the start cell marked.
                  mask_q            <= '0;
                  mask_q[start_idx] <= 1'b1;
                  busy              <= 1'b1;
                  state_q           <= S_POP;
               end
            end

            S_POP: begin
               cur_row_q  <= head_row;
               cur_col_q  <= head_col;
               st_rd_addr <= cell_idx(head_row, head_col);
               state_q    <= S_WAIT;
            end

            S_WAIT: begin
               state_q <= S_EVAL;
            end

            S_EVAL: begin
               if (cell_hidden) begin
                  st_we        <= 1'b1;
                  st_wr_addr   <= st_rd_addr;
                  st_wr_data   <= ST_REVEALED;
                  revealed_cnt <= revealed_cnt + (IDW+1)'(1);
                  if (num_rd_data == NUM_MINE) begin
                     hit_mine <= 1'b1;
                     state_q  <= S_DONE;
                  end else if (num_rd_data == NUM_ZERO) begin
                     dir_q   <= '0;
                     state_q <= S_NEIGH;
                  end else begin
                     state_q <= fifo_empty ? S_DONE : S_POP;
                  end
               end else begin
                  // Revealed or flagged: left untouched and not expanded.
                  state_q <= fifo_empty ? S_DONE : S_POP;
               end
            end

            S_NEIGH: begin
               if (nb_push) begin
                  mask_q[nb_idx] <= 1'b1;
               end
               dir_q <= dir_q + 3'd1;
               if (dir_q == 3'd7) begin
                  // The push made this cycle counts toward "non-empty".
                  state_q <= (!fifo_empty || nb_push) ? S_POP : S_DONE;
               end
            end

            S_DONE: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               state_q <= S_IDLE;
            end

            default: begin
               busy    <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flood_reveal_ctrl.sv
module tb_flood_reveal_ctrl;
   import minesweeper_pkg::*;

   localparam int ROWS  = 5;
   localparam int COLS  = 5;
   localparam int CELLS = 25;
   localparam int MINES = 4;
   localparam int IDW   = 5;

   // Board kinds
   localparam int B_NUM2   = 0; // all hidden, every number 2
   localparam int B_MINE24 = 1; // zeros, mine at 24, 18/19/23 = 1
   localparam int B_MINE12 = 2; // every number 1, mine at 12
   localparam int B_FLAG3  = 3; // zeros, cell 3 flagged
   localparam int B_ZERO   = 4; // all zeros
   localparam int B_WIN    = 5; // mines at 21..24

   logic           clock;
   logic           reset_n;
   logic           flip;
   logic [31:0]    flip_id;
   logic [IDW-1:0] st_rd_addr;
   logic [1:0]     st_rd_data;
   logic [3:0]     num_rd_data;
   logic           st_we;
   logic [IDW-1:0] st_wr_addr;
   logic [1:0]     st_wr_data;
   logic           busy;
   logic           done;
   logic           hit_mine;
   logic           win;
   logic [IDW:0]   revealed_cnt;
   logic [2:0]     dbg_state;

   flood_reveal_ctrl #(
      .ROWS(ROWS), .COLS(COLS), .CELLS(CELLS), .MINES(MINES), .IDW(IDW)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .flip         (flip),
      .flip_id      (flip_id),
      .st_rd_addr   (st_rd_addr),
      .st_rd_data   (st_rd_data),
      .num_rd_data  (num_rd_data),
      .st_we        (st_we),
      .st_wr_addr   (st_wr_addr),
      .st_wr_data   (st_wr_data),
      .busy         (busy),
      .done         (done),
      .hit_mine     (hit_mine),
      .win          (win),
      .revealed_cnt (revealed_cnt),
      .dbg_state    (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // ---------------- board storage model ----------------
   logic [1:0] st_mem  [32];
   logic [3:0] num_mem [32];

   always @(posedge clock) begin
      st_rd_data  <= st_mem[st_rd_addr];
      num_rd_data <= num_mem[st_rd_addr];
      if (st_we) st_mem[st_wr_addr] = st_wr_data;
   end

   // ---------------- scoreboard counters ----------------
   int checks = 0;
   int errors = 0;
   int wr_total, done_cnt, busy_cyc, done_cyc;
   int wr_cnt [32];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (st_we) begin
         wr_total++;
         wr_cnt[st_wr_addr]++;
         check("wr_data_revealed", int'(st_wr_data), int'(ST_REVEALED));
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy) busy_cyc++;
   end

   task automatic clear_mon();
      wr_total = 0;
      done_cnt = 0;
      busy_cyc = 0;
      done_cyc = -1;
      for (int i = 0; i < 32; i++) wr_cnt[i] = 0;
   endtask

   function automatic int dup_count();
      int n = 0;
      for (int i = 0; i < 32; i++) if (wr_cnt[i] > 1) n++;
      return n;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      reset_n = 1'b0;
      flip    = 1'b0;
      flip_id = '0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic load_board(input int kind);
      for (int i = 0; i < 32; i++) begin
         st_mem[i] = ST_HIDDEN;
         case (kind)
            B_NUM2:   num_mem[i] = 4'd2;
            B_MINE12: num_mem[i] = (i == 12) ? NUM_MINE : 4'd1;
            default:  num_mem[i] = 4'd0;
         endcase
      end
      if (kind == B_MINE24) begin
         num_mem[24] = NUM_MINE;
         num_mem[18] = 4'd1; num_mem[19] = 4'd1; num_mem[23] = 4'd1;
      end
      if (kind == B_FLAG3) st_mem[3] = ST_FLAGGED;
      if (kind == B_WIN) begin
         for (int i = 21; i < 25; i++) num_mem[i] = NUM_MINE;
         num_mem[15] = 4'd1; num_mem[16] = 4'd2; num_mem[17] = 4'd3;
         num_mem[18] = 4'd3; num_mem[19] = 4'd2; num_mem[20] = 4'd1;
      end
   endtask

   // One-cycle rising edge on flip; returns the cycle stamp of the edge.
   task automatic pulse(input int id, output int t0);
      @(negedge clock);
      flip_id = 32'(id);
      flip    = 1'b1;
      t0      = cyc;
      @(negedge clock);
      flip    = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge clock);
         #1;
         n++;
      end
      check("done_reached", int'(done_cnt >= target), 1);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clock);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int brd;
      int id;
      int exp_wr;
      int exp_cnt;
      int exp_hit;
      int exp_done;
      int exp_busy;  // -1: not checked
      int exp_lat;   // -1: not checked
      int must_wr;   // address written exactly once, -1: none
      int no_wr;     // address never written, -1: none
   } vec_t;

   vec_t vecs [10];

   initial begin
      int t0;
      int wr_before;
      int mem_revealed;

      vecs[0] = '{B_NUM2,    7,  1,  1, 0, 1,  4,  5,  7, -1};
      vecs[1] = '{B_MINE24,  0, 24, 24, 0, 1, -1, -1,  0, 24};
      vecs[2] = '{B_MINE12, 12,  1,  1, 1, 1,  4,  5, 12, -1};
      vecs[3] = '{B_FLAG3,   3,  0,  0, 0, 1,  4,  5, -1,  3};
      vecs[4] = '{B_FLAG3,   0, 24, 24, 0, 1, -1, -1,  4,  3};
      vecs[5] = '{B_NUM2,   25,  0,  0, 0, 0,  0, -1, -1, 25};
      vecs[6] = '{B_NUM2,   24,  1,  1, 0, 1,  4,  5, 24, -1};
      vecs[7] = '{B_NUM2,    0,  1,  1, 0, 1,  4,  5,  0, -1};
      vecs[8] = '{B_ZERO,   12, 25, 25, 0, 1, -1, -1, 12, -1};
      vecs[9] = '{B_MINE24, 18,  1,  1, 0, 1,  4,  5, 18, -1};

      clear_mon();
      load_board(B_NUM2);

      // Reset state
      reset_n = 1'b0;
      flip    = 1'b0;
      flip_id = '0;
      repeat (2) @(negedge clock);
      check("rst_outputs", int'({busy, done, st_we, hit_mine, win, revealed_cnt,
                                 st_rd_addr, st_wr_addr, st_wr_data}), 0);
      check("rst_state", int'(dbg_state), int'(S_IDLE));
      reset_n = 1'b1;
      @(negedge clock);
      check("rst_release_cnt", int'(revealed_cnt), 0);

      // Table-driven single operations
      foreach (vecs[v]) begin
         do_reset();
         load_board(vecs[v].brd);
         clear_mon();
         pulse(vecs[v].id, t0);
         if (vecs[v].exp_done > 0) wait_done(1, 2000);
         idle_cycles(12);
         check($sformatf("v%0d_done", v), done_cnt, vecs[v].exp_done);
         check($sformatf("v%0d_writes", v), wr_total, vecs[v].exp_wr);
         check($sformatf("v%0d_cnt", v), int'(revealed_cnt), vecs[v].exp_cnt);
         check($sformatf("v%0d_hit", v), int'(hit_mine), vecs[v].exp_hit);
         check($sformatf("v%0d_win", v), int'(win), 0);
         check($sformatf("v%0d_dups", v), dup_count(), 0);
         check($sformatf("v%0d_idle", v), int'(dbg_state), int'(S_IDLE));
         if (vecs[v].exp_busy >= 0)
            check($sformatf("v%0d_busy_cyc", v), busy_cyc, vecs[v].exp_busy);
         if (vecs[v].exp_lat >= 0)
            check($sformatf("v%0d_latency", v), done_cyc - t0, vecs[v].exp_lat);
         if (vecs[v].must_wr >= 0)
            check($sformatf("v%0d_wr_addr", v), wr_cnt[vecs[v].must_wr], 1);
         if (vecs[v].no_wr >= 0)
            check($sformatf("v%0d_no_wr", v), wr_cnt[vecs[v].no_wr], 0);
      end

      // After a mine hit, further flips are ignored
      do_reset();
      load_board(B_MINE12);
      clear_mon();
      pulse(12, t0);
      wait_done(1, 200);
      idle_cycles(3);
      clear_mon();
      pulse(0, t0);
      idle_cycles(12);
      check("mine_then_busy", busy_cyc, 0);
      check("mine_then_writes", wr_total, 0);
      check("mine_then_done", done_cnt, 0);
      check("mine_sticky", int'(hit_mine), 1);

      // Out-of-range id, held flip, and a re-pulse while busy
      do_reset();
      load_board(B_MINE24);
      clear_mon();
      pulse(25, t0);
      idle_cycles(8);
      check("id25_busy", busy_cyc, 0);
      check("id25_done", done_cnt, 0);
      @(negedge clock);
      flip_id = 32'd0;
      flip    = 1'b1;
      repeat (10) @(negedge clock);
      flip = 1'b0;
      repeat (3) @(negedge clock);
      check("repulse_while_busy", int'(busy), 1);
      flip = 1'b1;
      @(negedge clock);
      flip = 1'b0;
      wait_done(1, 2000);
      idle_cycles(20);
      check("held_done_count", done_cnt, 1);
      check("held_writes", wr_total, 24);
      check("held_cnt", int'(revealed_cnt), 24);

      // Reset in the middle of a flood
      do_reset();
      load_board(B_MINE24);
      clear_mon();
      pulse(0, t0);
      begin
         int n = 0;
         while (wr_total < 6 && n < 500) begin
            @(negedge clock);
            #1;
            n++;
         end
      end
      check("midflood_writes_seen", wr_total, 6);
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      check("midflood_rst_outputs", int'({busy, done, st_we, hit_mine, win, revealed_cnt,
                                          st_rd_addr, st_wr_addr, st_wr_data}), 0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      idle_cycles(2);
      mem_revealed = 0;
      for (int i = 0; i < 32; i++) if (st_mem[i] == ST_REVEALED) mem_revealed++;
      check("midflood_mem_revealed", mem_revealed, 6);
      check("midflood_no_rst_writes", wr_total, 6);
      wr_before = done_cnt;
      pulse(0, t0);
      wait_done(wr_before + 1, 200);
      idle_cycles(3);
      check("reflip0_writes", wr_total, 6);
      check("reflip0_cnt", int'(revealed_cnt), 0);
      pulse(12, t0);
      wait_done(wr_before + 2, 2000);
      idle_cycles(5);
      check("refill_writes", wr_total, 24);
      check("refill_cnt", int'(revealed_cnt), 18);
      check("refill_dups", dup_count(), 0);
      check("refill_no_mine", wr_cnt[24], 0);

      // Win detection and lockout
      do_reset();
      load_board(B_WIN);
      clear_mon();
      pulse(0, t0);
      wait_done(1, 2000);
      idle_cycles(3);
      check("win_flood_cnt", int'(revealed_cnt), 20);
      check("win_flood_win", int'(win), 0);
      pulse(20, t0);
      wait_done(2, 200);
      idle_cycles(3);
      check("win_cnt", int'(revealed_cnt), 21);
      check("win_flag", int'(win), 1);
      check("win_no_hit", int'(hit_mine), 0);
      clear_mon();
      pulse(21, t0);
      idle_cycles(12);
      check("win_lock_busy", busy_cyc, 0);
      check("win_lock_writes", wr_total, 0);
      check("win_still", int'(win), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
